// File: rtl/shreg_pkg.sv
// Shared definitions for the shreg_bank register bank: operation encodings
// and the width of the fill counter.
package shreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ROTATE = 2'b11
  } shreg_mode_e;

  // Bits needed to count 0..depth inclusive.
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shreg_stage.sv
// One WIDTH-bit stage of the register bank. Async active-high reset to
// RST_VAL, load enable, and (with SHREG_SYNC_CLR_EN) a synchronous clear that
// wins over the enable.
module shreg_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef SHREG_SYNC_CLR_EN
  input  logic             clr,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage register: reset, then clear, then enabled load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end
`ifdef SHREG_SYNC_CLR_EN
    else if (clr) begin
      q <= RST_VAL;
    end
`endif
    else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shreg_bank.sv
// Universal WIDTH x DEPTH register bank: hold, serial shift, parallel load and
// rotate with a per-cycle enable and a saturating fill counter.
// Optional feature macro: SHREG_SYNC_CLR_EN adds the synchronous clr port.
module shreg_bank
  import shreg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              FW      = fill_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin,
  input  logic [DEPTH*WIDTH-1:0] pin,
`ifdef SHREG_SYNC_CLR_EN
  input  logic                   clr,
`endif
  output logic [WIDTH-1:0]       sout,
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic [FW-1:0]          fill,
  output logic                   full
);

  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  logic [WIDTH-1:0] q         [DEPTH];
  logic [WIDTH-1:0] d         [DEPTH];
  logic [WIDTH-1:0] shift_src [DEPTH];
  logic [WIDTH-1:0] rot_src   [DEPTH];
  logic             stage_en;

  // HOLD leaves the stages untouched, so it simply gates the stage enables.
  assign stage_en = en && (mode != MODE_HOLD);

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        // With DEPTH=1 the rotate source is the stage itself, i.e. a hold.
        assign shift_src[i] = sin;
        assign rot_src[i]   = q[DEPTH-1];
      end else begin : g_body
        assign shift_src[i] = q[i-1];
        assign rot_src[i]   = q[i-1];
      end

      // Next-value select for this stage.
      always_comb begin
        d[i] = shift_src[i];
        case (mode)
          MODE_LOAD:   d[i] = pin[i*WIDTH +: WIDTH];
          MODE_ROTATE: d[i] = rot_src[i];
          default:     d[i] = shift_src[i];
        endcase
      end

      shreg_stage #(
        .WIDTH  (WIDTH),
        .RST_VAL(RST_VAL)
      ) u_stage (
        .clk(clk),
        .rst(rst),
        .en (stage_en),
`ifdef SHREG_SYNC_CLR_EN
        .clr(clr),
`endif
        .d  (d[i]),
        .q  (q[i])
      );

      assign pout[i*WIDTH +: WIDTH] = q[i];
    end
  endgenerate

  assign sout = q[DEPTH-1];
  assign full = (fill == DEPTH_F);

  // Fill counter: counts shifted-in stages, saturates at DEPTH, jumps to
  // DEPTH on load; rotate and hold leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end
`ifdef SHREG_SYNC_CLR_EN
    else if (clr) begin
      fill <= '0;
    end
`endif
    else if (en) begin
      case (mode)
        MODE_SHIFT: if (fill != DEPTH_F) fill <= fill + FW'(1);
        MODE_LOAD:  fill <= DEPTH_F;
        default:    fill <= fill;
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_bank.sv
// Directed self-checking bench for shreg_bank with WIDTH=8, DEPTH=4.
// Define SHREG_SYNC_CLR_EN to also exercise the synchronous clear.
module tb_shreg_bank;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int FW    = $clog2(DEPTH + 1);

  localparam logic [1:0] M_HOLD   = 2'b00;
  localparam logic [1:0] M_SHIFT  = 2'b01;
  localparam logic [1:0] M_LOAD   = 2'b10;
  localparam logic [1:0] M_ROTATE = 2'b11;

  logic                   clk;
  logic                   rst;
  logic                   en;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       sin;
  logic [DEPTH*WIDTH-1:0] pin;
  logic                   clr;
  logic [WIDTH-1:0]       sout;
  logic [DEPTH*WIDTH-1:0] pout;
  logic [FW-1:0]          fill;
  logic                   full;

  int errors = 0;
  int checks = 0;

  shreg_bank #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RST_VAL('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .sin (sin),
    .pin (pin),
`ifdef SHREG_SYNC_CLR_EN
    .clr (clr),
`endif
    .sout(sout),
    .pout(pout),
    .fill(fill),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic cycle(input logic e, input logic [1:0] m,
                       input logic [WIDTH-1:0] s, input logic [DEPTH*WIDTH-1:0] p);
    en = e; mode = m; sin = s; pin = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = M_HOLD; sin = '0; pin = '0; clr = 1'b0;
    #2;
    checks++; if (pout !== 32'h0) begin errors++; $display("FAIL reset_pout got=%h exp=%h", pout, 32'h0); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_shift();
    cycle(1'b1, M_SHIFT, 8'h11, '0);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL shift_fill1 got=%0d exp=1", fill); end
    cycle(1'b1, M_SHIFT, 8'h22, '0);
    cycle(1'b1, M_SHIFT, 8'h33, '0);
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL shift_full3 got=%b exp=0", full); end
    cycle(1'b1, M_SHIFT, 8'h44, '0);
    checks++; if (pout !== 32'h11223344) begin errors++; $display("FAIL shift_pout got=%h exp=%h", pout, 32'h11223344); end
    checks++; if (sout !== 8'h11) begin errors++; $display("FAIL shift_sout got=%h exp=11", sout); end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL shift_fill4 got=%0d exp=4", fill); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL shift_full got=%b exp=1", full); end
    cycle(1'b1, M_SHIFT, 8'h55, '0);
    checks++; if (sout !== 8'h22) begin errors++; $display("FAIL shift5_sout got=%h exp=22", sout); end
    checks++; if (pout !== 32'h22334455) begin errors++; $display("FAIL shift5_pout got=%h exp=%h", pout, 32'h22334455); end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL shift5_fill_sat got=%0d exp=4", fill); end
  endtask

  task automatic test_load_rotate();
    cycle(1'b1, M_LOAD, 8'h00, 32'hDDCCBBAA);
    checks++; if (pout !== 32'hDDCCBBAA) begin errors++; $display("FAIL load_pout got=%h exp=%h", pout, 32'hDDCCBBAA); end
    checks++; if (sout !== 8'hDD) begin errors++; $display("FAIL load_sout got=%h exp=dd", sout); end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL load_fill got=%0d exp=4", fill); end
    cycle(1'b1, M_ROTATE, 8'hEE, 32'h0);
    checks++; if (pout !== 32'hCCBBAADD) begin errors++; $display("FAIL rot1_pout got=%h exp=%h", pout, 32'hCCBBAADD); end
    checks++; if (sout !== 8'hCC) begin errors++; $display("FAIL rot1_sout got=%h exp=cc", sout); end
    cycle(1'b1, M_ROTATE, 8'hEE, 32'h0);
    checks++; if (pout !== 32'hBBAADDCC) begin errors++; $display("FAIL rot2_pout got=%h exp=%h", pout, 32'hBBAADDCC); end
    cycle(1'b1, M_ROTATE, 8'hEE, 32'h0);
    cycle(1'b1, M_ROTATE, 8'hEE, 32'h0);
    checks++; if (pout !== 32'hDDCCBBAA) begin errors++; $display("FAIL rot4_pout got=%h exp=%h", pout, 32'hDDCCBBAA); end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL rot4_fill got=%0d exp=4", fill); end
  endtask

  task automatic test_enable_hold();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, M_SHIFT, 8'hFF, 32'h12345678);
      checks++; if (pout !== 32'hDDCCBBAA) begin errors++; $display("FAIL en0_pout[%0d] got=%h exp=%h", k, pout, 32'hDDCCBBAA); end
    end
    cycle(1'b0, M_LOAD, 8'hFF, 32'h12345678);
    checks++; if (pout !== 32'hDDCCBBAA) begin errors++; $display("FAIL en0_load_pout got=%h exp=%h", pout, 32'hDDCCBBAA); end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL en0_fill got=%0d exp=4", fill); end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, M_SHIFT, 8'h5A, '0);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (pout !== 32'h0) begin errors++; $display("FAIL arst_pout got=%h exp=%h", pout, 32'h0); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL arst_fill got=%0d exp=0", fill); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL arst_full got=%b exp=0", full); end
    // An edge while rst is high must not update anything.
    en = 1'b1; mode = M_LOAD; pin = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    checks++; if (pout !== 32'h0) begin errors++; $display("FAIL arst_edge_pout got=%h exp=%h", pout, 32'h0); end
    rst = 1'b0;
    cycle(1'b1, M_SHIFT, 8'h77, '0);
    checks++; if (pout !== 32'h00000077) begin errors++; $display("FAIL arst_first_pout got=%h exp=%h", pout, 32'h77); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL arst_first_fill got=%0d exp=1", fill); end
  endtask

  task automatic test_partial_fill();
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cycle(1'b1, M_SHIFT, 8'hA1, '0);
    cycle(1'b1, M_SHIFT, 8'hA2, '0);
    checks++; if (fill !== 3'd2) begin errors++; $display("FAIL part_fill got=%0d exp=2", fill); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL part_full got=%b exp=0", full); end
    checks++; if (pout !== 32'h0000A1A2) begin errors++; $display("FAIL part_pout got=%h exp=%h", pout, 32'h0000A1A2); end
    checks++; if (sout !== 8'h00) begin errors++; $display("FAIL part_sout got=%h exp=00", sout); end
    cycle(1'b1, M_HOLD, 8'hBB, 32'h11111111);
    cycle(1'b1, M_HOLD, 8'hBB, 32'h11111111);
    checks++; if (pout !== 32'h0000A1A2) begin errors++; $display("FAIL hold_pout got=%h exp=%h", pout, 32'h0000A1A2); end
    checks++; if (fill !== 3'd2) begin errors++; $display("FAIL hold_fill got=%0d exp=2", fill); end
  endtask

`ifdef SHREG_SYNC_CLR_EN
  task automatic test_sync_clear();
    cycle(1'b1, M_LOAD, 8'h00, 32'h01020304);
    clr = 1'b1;
    cycle(1'b1, M_LOAD, 8'h00, 32'hCAFEF00D);
    clr = 1'b0;
    checks++; if (pout !== 32'h0) begin errors++; $display("FAIL clr_pout got=%h exp=%h", pout, 32'h0); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL clr_fill got=%0d exp=0", fill); end
    cycle(1'b1, M_LOAD, 8'h00, 32'h01020304);
    clr = 1'b1;
    cycle(1'b0, M_SHIFT, 8'h99, '0);
    clr = 1'b0;
    checks++; if (pout !== 32'h0) begin errors++; $display("FAIL clr_en0_pout got=%h exp=%h", pout, 32'h0); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL clr_en0_fill got=%0d exp=0", fill); end
  endtask
`endif

  initial begin
    test_reset();
    test_shift();
    test_load_rotate();
    test_enable_hold();
    test_async_reset();
    test_partial_fill();
`ifdef SHREG_SYNC_CLR_EN
    test_sync_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shreg_bank.md
# shreg_bank

Parametrised W-bit × DEPTH-stage universal register bank: the multi-bit, multi-stage successor to the single-bit D flip-flop cells. Supports hold, serial shift, parallel load and rotate, with per-cycle enable and a saturating fill counter. It sits between serial/parallel data sources and downstream datapath logic as a configurable delay line or staging buffer.

## Interface
- WIDTH, 8, bits per stage (≥1)
- DEPTH, 4, number of stages (≥1)
- RST_VAL, 0, WIDTH-bit value loaded into every stage on reset/clear
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  cycle enable; 0 = everything holds
- mode  input  2  operation select (see Operation)
- sin  input  WIDTH  serial data in (stage 0)
- pin  input  DEPTH*WIDTH  parallel load data; stage i = pin[i*WIDTH +: WIDTH]
- clr  input  1  synchronous clear (present only with SHREG_SYNC_CLR_EN)
- sout  output  WIDTH  stage DEPTH-1 contents
- pout  output  DEPTH*WIDTH  all stages, same packing as pin
- fill  output  $clog2(DEPTH+1)  number of valid stages
- full  output  1  fill == DEPTH

## Operation
- Reset (rst=1): all stages = RST_VAL, fill = 0, full = 0; takes effect immediately, independent of clk, and overrides all inputs.
- Priority per rising edge: clr (if compiled) > en=0 > mode.
- mode 2'b00 HOLD: no change.
- mode 2'b01 SHIFT: stage0 ← sin, stage[i] ← stage[i-1]; fill ← min(fill+1, DEPTH).
- mode 2'b10 LOAD: stage[i] ← pin slice i; fill ← DEPTH.
- mode 2'b11 ROTATE: stage0 ← stage[DEPTH-1], stage[i] ← stage[i-1]; fill unchanged.
- DEPTH=1: ROTATE behaves as HOLD; SHIFT replaces the single stage.
- en=0: stages and fill hold for any mode.
- fill saturates at DEPTH; never wraps. full is combinational from fill.
- sout and pout are driven directly from stage registers (no output logic).

## Timing
- All state updates on the rising clk edge; outputs valid after clock-to-q.
- SHIFT latency: sin sampled at edge k appears on sout after DEPTH enabled SHIFT edges.
- LOAD/ROTATE: new values visible one edge after the command.
- rst asserted mid-cycle: outputs go to reset values immediately; first update after deassertion occurs at the next rising edge with rst=0.
- rst deassertion is synchronised externally; the block performs no resynchronisation.

## Configuration
- SHREG_SYNC_CLR_EN defined: clr port exists; clr=1 at a rising edge sets all stages to RST_VAL and fill to 0, regardless of en and mode.
- Undefined: no clr port; stages and fill return to reset values only via rst.

## Structure
- Package shreg_pkg: mode encodings MODE_HOLD, MODE_SHIFT, MODE_LOAD, MODE_ROTATE, plus fill width function.
- Sub-module shreg_stage: one WIDTH-bit register with async active-high reset to RST_VAL, enable, and optional sync clear; instantiated DEPTH times via generate. Next-state mux and fill counter live in the top level.

## Test plan
- WIDTH=8, DEPTH=4. Assert rst between clock edges during activity -> pout=0x00000000, fill=0, full=0 before the next edge.
- SHIFT 0x11,0x22,0x33,0x44 -> pout=0x11223344 (stage0=0x44), sout=0x11, fill=4, full=1; SHIFT 0x55 -> sout=0x22, fill stays 4.
- LOAD pin=0xDDCCBBAA -> sout=0xDD, fill=4; ROTATE -> stage0=0xDD, stage1=0xAA, sout=0xCC; 4 ROTATEs total -> pout back to 0xDDCCBBAA.
- en=0 with mode=SHIFT, sin=0xFF for 3 edges -> pout and fill unchanged.
- SHREG_SYNC_CLR_EN: clr=1 with mode=LOAD, en=1 -> pout=0, fill=0 after the edge; en=0, clr=1 -> still cleared.
- Partial fill: rst, then SHIFT 0xA1,0xA2 -> fill=2, full=0, pout=0x0000A1A2; HOLD 2 edges -> unchanged.
